// File: rtl/tile_pkg.sv
// Shared constants and types for the snake tile memory arbiter.
package tile_pkg;

  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned DATA_W     = 2;

  localparam logic [DATA_W-1:0] EMPTY = 2'd0;
  localparam logic [DATA_W-1:0] SNAKE = 2'd1;
  localparam logic [DATA_W-1:0] FOOD  = 2'd2;
  localparam logic [DATA_W-1:0] WALL  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tile_mem_arbiter_if.sv
// Game-side req/ack access channel into the tile memory arbiter.
interface tile_mem_arbiter_if #(
  parameter int unsigned ADDR_W = tile_pkg::ADDR_W,
  parameter int unsigned DATA_W = tile_pkg::DATA_W
) ();

  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_ack;
  logic [DATA_W-1:0] g_rdata;

  modport master (
    output g_req, g_we, g_addr, g_wdata,
    input  g_ack, g_rdata
  );

  modport slave (
    input  g_req, g_we, g_addr, g_wdata,
    output g_ack, g_rdata
  );

endinterface

// File: rtl/frame_step_counter.sv
// Counts vsync falling edges and pulses step_tick once every STEP_FRAMES frames.
module frame_step_counter #(
  parameter int unsigned STEP_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vga_v_sync,
  output logic step_tick
);

  localparam int unsigned CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  logic             vs_q, vs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    vs_d   = vga_v_sync;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (vs_q && !vga_v_sync) begin
      if (cnt_q == CNT_W'(STEP_FRAMES - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b1;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= vs_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign step_tick = tick_q;

endmodule

// File: rtl/tile_mem_arbiter.sv
// Shares the tile RAM port between video fetch (display area) and game req/ack (blanking).
// Build option STEP_TICK_EN adds the vsync-derived step_tick; otherwise step_tick is 0.
module tile_mem_arbiter #(
  parameter int unsigned GRID_W      = tile_pkg::GRID_W,
  parameter int unsigned GRID_H      = tile_pkg::GRID_H,
  parameter int unsigned TILE_SHIFT  = tile_pkg::TILE_SHIFT,
  parameter int unsigned ADDR_W      = tile_pkg::ADDR_W,
  parameter int unsigned DATA_W      = tile_pkg::DATA_W,
  parameter int unsigned STEP_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_display,
  input  logic [9:0]        counter_x,
  input  logic [8:0]        counter_y,
  input  logic              vga_v_sync,
  tile_mem_arbiter_if.slave game,
  output logic [DATA_W-1:0] vid_tile,
  output logic              vid_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              step_tick
);

  import tile_pkg::*;

  localparam int unsigned ROW_W = $clog2(GRID_H);
  localparam int unsigned COL_W = $clog2(GRID_W);

  arb_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              vid_valid_q, vid_valid_d;

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] vid_addr;
  logic              video_on;
  logic              game_issue;

  // row*GRID_W as a sum of shifted rows, one term per set bit of GRID_W
  always_comb begin
    row      = ROW_W'(counter_y >> TILE_SHIFT);
    col      = COL_W'(counter_x >> TILE_SHIFT);
    vid_addr = ADDR_W'(col);
    for (int unsigned b = 0; b < 32; b++) begin
      if (GRID_W[b]) vid_addr = vid_addr + (ADDR_W'(row) << b);
    end
  end

  // rst_n gates the combinational port so nothing reaches the RAM during reset
  always_comb begin
    video_on    = rst_n & in_display;
    game_issue  = rst_n & ~in_display & (state_q == ST_IDLE) & game.g_req;

    state_d     = state_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    vid_valid_d = in_display;

    game.g_ack   = 1'b0;
    game.g_rdata = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (game_issue) begin
          state_d = ST_ACK;
          we_d    = game.g_we;
        end
      end
      ST_ACK: begin
        game.g_ack = 1'b1;
        state_d    = ST_IDLE;
        if (!we_q) begin
          rdata_d      = mem_rdata;
          game.g_rdata = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (video_on) begin
      mem_en   = 1'b1;
      mem_addr = vid_addr;
    end else if (game_issue) begin
      mem_en    = 1'b1;
      mem_we    = game.g_we;
      mem_addr  = game.g_addr;
      mem_wdata = game.g_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign vid_valid = vid_valid_q;
  assign vid_tile  = vid_valid_q ? mem_rdata : '0;

`ifdef STEP_TICK_EN
  frame_step_counter #(
    .STEP_FRAMES(STEP_FRAMES)
  ) u_frame_step_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_v_sync(vga_v_sync),
    .step_tick (step_tick)
  );
`else
  localparam int unsigned unused_step_frames = STEP_FRAMES;
  logic unused_vsync;
  always_comb unused_vsync = vga_v_sync;
  assign step_tick = 1'b0;
`endif

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

Shares the single-port snake tile memory (40×30 grid, 2-bit tiles) between the video tile fetcher and the game logic. Video owns the port whenever the sync generator reports the display area active. Game reads and writes are granted only during blanking through a req/ack handshake. The block also produces the per-step game tick, derived from counted vertical sync pulses, and sits between the VGA sync generator, the tile RAM and the snake game FSM.

## Interface
Parameters:
- GRID_W, 40, tiles per row (640 >> TILE_SHIFT)
- GRID_H, 30, tile rows (480 >> TILE_SHIFT)
- TILE_SHIFT, 4, log2 of tile edge in pixels
- ADDR_W, 11, tile address width (covers GRID_W*GRID_H = 1200)
- DATA_W, 2, tile code width
- STEP_FRAMES, 8, frames per game step (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock, same as sync generator
- rst_n  in  1  async active-low reset
- in_display  in  1  display-area flag from sync generator
- counter_x  in  10  sync generator X counter
- counter_y  in  9  sync generator Y counter
- vga_v_sync  in  1  active-low vertical sync
- g_req  in  1  game access request, held until g_ack
- g_we  in  1  1 = write, 0 = read
- g_addr  in  ADDR_W  game tile address
- g_wdata  in  DATA_W  write data
- g_ack  out  1  one-cycle completion pulse
- g_rdata  out  DATA_W  read data, valid with g_ack
- vid_tile  out  DATA_W  tile code for pixel fetched on previous cycle
- vid_valid  out  1  vid_tile valid (delayed in_display)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one-cycle synchronous read
- step_tick  out  1  one-cycle game step pulse

## Operation
- Port mux is combinational on in_display and state. When in_display=1: mem_en=1, mem_we=0, mem_addr = (counter_y>>TILE_SHIFT)*GRID_W + (counter_x>>TILE_SHIFT). The multiply is shift-add ((r<<5)+(r<<3) for GRID_W=40).
- FSM states:
  - IDLE: when in_display=0 and g_req=1, drive the game access onto the port this cycle (mem_en=1, mem_we=g_we) and go to ACK.
  - ACK: g_ack=1. g_rdata is registered from mem_rdata (reads only; unchanged on writes). Return to IDLE.
- Game throughput: at most one access per 2 cycles. Requester drops g_req or presents the next request after g_ack.
- A request raised during display waits; no grant and no ack occur while in_display=1.
- A game access occupies the port for its issue cycle only. Display starting in the ACK cycle does not conflict, because video issues that same cycle.
- vid_valid is in_display delayed by 1; vid_tile is mem_rdata registered when vid_valid is set, otherwise 0.
- Rows with counter_y ≥ 480, including the 9-bit wrap 480..511, are blank. The address calculation is never used there.
- Frame counter: on the falling edge of vga_v_sync, increment; at STEP_FRAMES-1, wrap to 0 and pulse step_tick for one cycle.
- Reset mid-access: an in-flight access is abandoned and no g_ack is issued. The requester re-issues after reset.

## Timing
- Reset values:
  - g_ack=0, g_rdata=0, vid_tile=0, vid_valid=0, step_tick=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - FSM in IDLE, frame counter=0, vsync edge register=1
- Game latency: g_req seen in blanking at cycle t → RAM access at t → g_ack and g_rdata at t+1.
- Video latency: address at cycle t → vid_tile at t+1.
- step_tick fires 1 cycle after the sync falling edge is sampled.

## Configuration
- STEP_TICK_EN defined: frame counter and step_tick logic are present as described.
- STEP_TICK_EN undefined: step_tick tied to 0 and vga_v_sync ignored. The game steps from an external timer.

## Structure
- Shared package tile_pkg holds:
  - GRID_W, GRID_H, TILE_SHIFT, ADDR_W, DATA_W
  - tile code constants: EMPTY=0, SNAKE=1, FOOD=2, WALL=3
  - FSM state typedef
- One sub-module, frame_step_counter: vsync edge detect, modulo-STEP_FRAMES counter and step_tick. Instantiated only under STEP_TICK_EN.

## Test plan
- Reset with g_req=1 → all outputs 0; no g_ack until rst_n released and in_display=0.
- Write addr 0x4AF data 2 in blanking → mem_we=1, mem_addr=0x4AF same cycle; g_ack one cycle later. A subsequent read of 0x4AF → g_rdata=2.
- g_req raised at counter_x=100 with in_display=1 → no ack until in_display falls at counter_x=640. Ack arrives 1 cycle after that.
- Display at counter_x=37, counter_y=479 → mem_addr=1162 (29*40+2); vid_tile equals RAM contents 1 cycle later, with vid_valid=1.
- Eight vga_v_sync falling edges with STEP_FRAMES=8 → exactly one step_tick, on the 8th edge. With STEP_TICK_EN undefined, step_tick stays 0.
- Reset asserted in the ACK cycle → g_ack=0 immediately and the FSM is in IDLE.
